sync_fifo_8x8: RTL and testbench



---
 rtl/fifo_pkg.sv | 11 +
 rtl/fifo_ram.sv | 28 ++
 rtl/sync_fifo_8x8.sv | 96 +++++++++
 tb/tb_sync_fifo_8x8.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO geometry and pointer-width helper
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 8;

  function automatic int fifo_ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x WIDTH register array, one sync write port, one comb read port
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = fifo_ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately left unreset; occupancy tracking makes stale data unreachable.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_8x8.sv
// rtl/sync_fifo_8x8.sv - byte FIFO with registered read data, occupancy flags and misuse pulses
module sync_fifo_8x8
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = fifo_ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             wr_err,
  output logic             rd_err
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             wr_err_q, wr_err_d;
  logic             rd_err_q, rd_err_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] ram_rdata;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  always_comb begin
    // A simultaneous read frees the slot this write needs, so full does not block it.
    wr_acc   = wr_en && (!full || rd_en);
    rd_acc   = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    wr_err_d = wr_en && !wr_acc;
    rd_err_d = rd_en && !rd_acc;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      dout_d   = ram_rdata;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign count  = count_q;
  assign dout   = dout_q;
  assign wr_err = wr_err_q;
  assign rd_err = rd_err_q;

endmodule

// File: tb/tb_sync_fifo_8x8.sv
// tb/tb_sync_fifo_8x8.sv - directed plus randomized bench against a queue-based FIFO model
module tb_sync_fifo_8x8;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] din;
  logic       rd_en;
  logic [7:0] dout;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       wr_err;
  logic       rd_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q [$];
  logic [7:0] dout_m;
  logic       wr_err_m;
  logic       rd_err_m;

  always #5 clk = ~clk;

  sync_fifo_8x8 dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .din    (din),
    .rd_en  (rd_en),
    .dout   (dout),
    .full   (full),
    .empty  (empty),
    .count  (count),
    .wr_err (wr_err),
    .rd_err (rd_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".dout"},   32'(dout),   32'(dout_m));
    chk({tag, ".count"},  32'(count),  32'(q.size()));
    chk({tag, ".full"},   32'(full),   32'(q.size() == 8));
    chk({tag, ".empty"},  32'(empty),  32'(q.size() == 0));
    chk({tag, ".wr_err"}, 32'(wr_err), 32'(wr_err_m));
    chk({tag, ".rd_err"}, 32'(rd_err), 32'(rd_err_m));
  endtask

  task automatic model_reset();
    q.delete();
    dout_m   = 8'h00;
    wr_err_m = 1'b0;
    rd_err_m = 1'b0;
  endtask

  // Apply one cycle of requests, advance the model by the FIFO rules, then compare.
  task automatic cycle(input string tag, input logic we, input logic [7:0] d, input logic re);
    bit was_full, was_empty, wacc, racc;
    wr_en = we;
    din   = d;
    rd_en = re;
    @(posedge clk);
    was_full  = (q.size() == 8);
    was_empty = (q.size() == 0);
    wacc = we && (!was_full || re);
    racc = re && !was_empty;
    if (racc) dout_m = q.pop_front();
    if (wacc) q.push_back(d);
    wr_err_m = we && !wacc;
    rd_err_m = re && !racc;
    #1;
    chk_all(tag);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    int wprob, rprob;
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    rst = 1'b0;

    cycle("idle", 1'b0, 8'h00, 1'b0);
    cycle("idle", 1'b0, 8'h00, 1'b0);

    cycle("w3", 1'b1, 8'h11, 1'b0);
    cycle("w3", 1'b1, 8'h22, 1'b0);
    cycle("w3", 1'b1, 8'h33, 1'b0);
    chk("w3.count", 32'(count), 32'd3);
    cycle("r3", 1'b0, 8'h00, 1'b1);
    chk("r3.dout0", 32'(dout), 32'h11);
    cycle("r3", 1'b0, 8'h00, 1'b1);
    chk("r3.dout1", 32'(dout), 32'h22);
    cycle("r3", 1'b0, 8'h00, 1'b1);
    chk("r3.dout2", 32'(dout), 32'h33);
    chk("r3.empty", 32'(empty), 32'd1);

    for (int i = 0; i < 8; i++) cycle("fill", 1'b1, 8'hA0 + 8'(i), 1'b0);
    cycle("over", 1'b1, 8'hFF, 1'b0);
    chk("over.full", 32'(full), 32'd1);
    chk("over.count", 32'(count), 32'd8);
    chk("over.wr_err", 32'(wr_err), 32'd1);
    cycle("over_idle", 1'b0, 8'h00, 1'b0);
    chk("over.wr_err_clear", 32'(wr_err), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cycle("drain", 1'b0, 8'h00, 1'b1);
      chk("drain.dout", 32'(dout), 32'hA0 + 32'(i));
    end

    for (int i = 0; i < 8; i++) cycle("refill", 1'b1, 8'hA0 + 8'(i), 1'b0);
    cycle("full_rw", 1'b1, 8'h5C, 1'b1);
    chk("full_rw.dout", 32'(dout), 32'hA0);
    chk("full_rw.count", 32'(count), 32'd8);
    chk("full_rw.wr_err", 32'(wr_err), 32'd0);
    for (int i = 0; i < 7; i++) cycle("wrap", 1'b0, 8'h00, 1'b1);
    cycle("wrap_last", 1'b0, 8'h00, 1'b1);
    chk("wrap.dout", 32'(dout), 32'h5C);

    cycle("empty_rw", 1'b1, 8'h3D, 1'b1);
    chk("empty_rw.rd_err", 32'(rd_err), 32'd1);
    chk("empty_rw.dout", 32'(dout), 32'h5C);
    chk("empty_rw.count", 32'(count), 32'd1);
    cycle("empty_rw_rd", 1'b0, 8'h00, 1'b1);
    chk("empty_rw_rd.dout", 32'(dout), 32'h3D);
    cycle("rd_rej", 1'b0, 8'h00, 1'b1);
    cycle("rd_rej", 1'b0, 8'h00, 1'b1);
    chk("rd_rej.rd_err_hold", 32'(rd_err), 32'd1);

    for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 8'(8'h60 + i), 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("arst.count", 32'(count), 32'd0);
    chk("arst.empty", 32'(empty), 32'd1);
    chk("arst.full", 32'(full), 32'd0);
    chk("arst.dout", 32'(dout), 32'h00);
    chk("arst.errs", 32'({wr_err, rd_err}), 32'd0);
    model_reset();
    #1;
    rst = 1'b0;
    cycle("post_rst_w", 1'b1, 8'h77, 1'b0);
    cycle("post_rst_r", 1'b0, 8'h00, 1'b1);
    chk("post_rst.dout", 32'(dout), 32'h77);

    for (int phase = 0; phase < 4; phase++) begin
      case (phase)
        0:       begin wprob = 75; rprob = 25; end
        1:       begin wprob = 25; rprob = 75; end
        2:       begin wprob = 50; rprob = 50; end
        default: begin wprob = 90; rprob = 90; end
      endcase
      repeat (100) begin
        cycle("rand",
              ($urandom_range(0, 99) < wprob),
              8'($urandom),
              ($urandom_range(0, 99) < rprob));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
